// File: rtl/router_fsm_param_if.sv
// Router FSM bus interface.
// Groups the source/datapath status inputs and the state-decode outputs of
// router_fsm_param.
//   master : drives pkt_valid, data_in, parity_done, low_pkt_valid, fifo_full,
//            fifo_empty, soft_reset; observes the decodes
//   slave  : the FSM side (consumes status, drives detect_add .. timeout_err)
interface router_fsm_param_if #(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned ADDR_W = 2
);
  logic              pkt_valid;
  logic [ADDR_W-1:0] data_in;
  logic              parity_done;
  logic              low_pkt_valid;
  logic              fifo_full;
  logic [NUM_CH-1:0] fifo_empty;
  logic [NUM_CH-1:0] soft_reset;

  logic              detect_add;
  logic              lfd_state;
  logic              ld_state;
  logic              laf_state;
  logic              full_state;
  logic              write_enb_reg;
  logic              rst_int_reg;
  logic              busy;
  logic [ADDR_W-1:0] dest_sel;
  logic              drop_pkt;
  logic              timeout_err;

  modport master (
    output pkt_valid, data_in, parity_done, low_pkt_valid, fifo_full, fifo_empty, soft_reset,
    input  detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg,
           rst_int_reg, busy, dest_sel, drop_pkt, timeout_err
  );

  modport slave (
    input  pkt_valid, data_in, parity_done, low_pkt_valid, fifo_full, fifo_empty, soft_reset,
    output detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg,
           rst_int_reg, busy, dest_sel, drop_pkt, timeout_err
  );
endinterface

// File: rtl/router_fsm_param.sv
// Router control FSM, parameterised on channel count.
// Decodes the header address of each packet, waits for the destination FIFO to
// drain, sequences first-data / data / parity loads, handles FIFO-full stalls and
// discards packets addressed to a non-existent channel.
// Ports:
//   clock  : single clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : router_fsm_param_if.slave (status inputs, Moore state decodes, dest_sel)
// Optional feature: define ROUTER_FSM_TIMEOUT_EN to bound the WAIT_TILL_EMPTY state by
// WAIT_MAX cycles; on expiry the packet is dropped and timeout_err pulses once.
module router_fsm_param #(
  parameter int unsigned NUM_CH   = 3,
  parameter int unsigned ADDR_W   = 2,
  parameter int unsigned WAIT_MAX = 255
) (
  input logic                clock,
  input logic                resetn,
  router_fsm_param_if.slave  bus
);

  typedef enum logic [3:0] {
    StDecode, StWait, StLfd, StLoad, StParity, StFull, StLaf, StCheck, StDrop
  } state_e;

  localparam logic [ADDR_W:0] NumChW = NUM_CH[ADDR_W:0];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] dest_sel_q, dest_sel_d;
  logic              empty_sel;  // fifo_empty[dest_sel], 0 when out of range
  logic              soft_sel;   // soft_reset[dest_sel], 0 when out of range
  logic              empty_in;   // fifo_empty[data_in], 0 when out of range
  logic              addr_bad;
  logic              timeout_hit;

  // Range-safe lookups: only indices below NUM_CH ever select a bit.
  always_comb begin
    empty_sel = 1'b0;
    soft_sel  = 1'b0;
    empty_in  = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (dest_sel_q == ADDR_W'(i)) begin
        empty_sel = bus.fifo_empty[i];
        soft_sel  = bus.soft_reset[i];
      end
      if (bus.data_in == ADDR_W'(i)) begin
        empty_in = bus.fifo_empty[i];
      end
    end
  end

  assign addr_bad = ({1'b0, bus.data_in} >= NumChW);

`ifdef ROUTER_FSM_TIMEOUT_EN
  localparam logic [15:0] WaitLast = 16'(WAIT_MAX - 1);

  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        timeout_err_q;

  // An empty flag or a soft reset in the expiry cycle takes precedence.
  assign timeout_hit = (state_q == StWait) && (wait_cnt_q == WaitLast) && !empty_sel
                       && !soft_sel;
  // Zero outside WAIT so every entry starts counting from 0.
  assign wait_cnt_d  = ((state_q == StWait) && (state_d == StWait)) ? wait_cnt_q + 16'd1
                                                                     : 16'd0;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wait_cnt_q    <= 16'd0;
      timeout_err_q <= 1'b0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_hit;
    end
  end

  assign bus.timeout_err = timeout_err_q;
`else
  logic unused_wait_max;
  assign unused_wait_max = |WAIT_MAX;
  assign timeout_hit     = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StDecode;
      dest_sel_q <= '0;
    end else begin
      state_q    <= state_d;
      dest_sel_q <= dest_sel_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    dest_sel_d = dest_sel_q;
    unique case (state_q)
      StDecode: begin
        if (bus.pkt_valid) begin
          dest_sel_d = bus.data_in;
          if (addr_bad)      state_d = StDrop;
          else if (empty_in) state_d = StLfd;
          else               state_d = StWait;
        end
      end
      StWait: begin
        if (empty_sel)        state_d = StLfd;
        else if (timeout_hit) state_d = StDrop;
      end
      StLfd:    state_d = StLoad;
      StLoad: begin
        if (bus.fifo_full)       state_d = StFull;
        else if (!bus.pkt_valid) state_d = StParity;
      end
      StFull: begin
        if (!bus.fifo_full) state_d = StLaf;
      end
      StLaf: begin
        if (bus.parity_done)        state_d = StDecode;
        else if (bus.low_pkt_valid) state_d = StParity;
        else                        state_d = StLoad;
      end
      StParity: state_d = StCheck;
      StCheck:  state_d = bus.fifo_full ? StFull : StDecode;
      StDrop: begin
        if (!bus.pkt_valid) state_d = StDecode;
      end
      default:  state_d = StDecode;
    endcase
    // Soft reset of the selected channel aborts the packet from any active state.
    if ((state_q != StDecode) && soft_sel) state_d = StDecode;
  end

  // Moore output decodes
  always_comb begin
    bus.detect_add    = 1'b0;
    bus.lfd_state     = 1'b0;
    bus.ld_state      = 1'b0;
    bus.laf_state     = 1'b0;
    bus.full_state    = 1'b0;
    bus.write_enb_reg = 1'b0;
    bus.rst_int_reg   = 1'b0;
    bus.busy          = 1'b0;
    bus.drop_pkt      = 1'b0;
    unique case (state_q)
      StDecode: bus.detect_add = 1'b1;
      StWait:   bus.busy = 1'b1;
      StLfd: begin
        bus.lfd_state = 1'b1;
        bus.busy      = 1'b1;
      end
      StLoad: begin
        bus.ld_state      = 1'b1;
        bus.write_enb_reg = 1'b1;
      end
      StParity: begin
        bus.write_enb_reg = 1'b1;
        bus.busy          = 1'b1;
      end
      StFull: begin
        bus.full_state = 1'b1;
        bus.busy       = 1'b1;
      end
      StLaf: begin
        bus.laf_state     = 1'b1;
        bus.write_enb_reg = 1'b1;
        bus.busy          = 1'b1;
      end
      StCheck: begin
        bus.rst_int_reg = 1'b1;
        bus.busy        = 1'b1;
      end
      StDrop:   bus.drop_pkt = 1'b1;
      default:  bus.detect_add = 1'b0;
    endcase
  end

  assign bus.dest_sel = dest_sel_q;

endmodule
